hazard_stall_ctrl: RTL and testbench

- ID-stage hazard controller, directly upstream of forwarding_unit.
- Detects load-use hazards that forwarding cannot cover and stalls PC and IF/ID while inserting ID/EX bubbles.
- On a taken branch resolved in EX, flushes IF/ID and ID/EX for a programmable number of cycles.
- Small FSM plus down-counter; drives the pipeline-register enables for the double-issue MIPS core.

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/load_use_detect.sv | 25 ++
 rtl/hazard_stall_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM encodings, MIPS opcodes, register index width.
package pipeline_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    StRun   = 2'b00,
    StStall = 2'b01,
    StFlush = 2'b10
  } hazard_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Instructions whose rt field is a source operand rather than a destination.
  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_BNE) ||
           (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare for one issue slot: EX-stage load vs ID-stage sources.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic [31:0]      instruction,
  input  logic             mem_read,
  input  logic [REG_W-1:0] write_register,
  output logic             load_use
);

  logic [5:0]       opcode;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic             unused_imm;

  assign opcode     = instruction[31:26];
  assign rs         = instruction[25:21];
  assign rt         = instruction[20:16];
  assign unused_imm = ^instruction[15:0];

  // A load into $0 never produces a value, so it can never cause a hazard.
  assign load_use = mem_read && (write_register != '0) &&
                    ((write_register == rs) || (uses_rt(opcode) && (write_register == rt)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard controller: load-use stalls and taken-branch flushes with a cycle counter.
// Optional perf counters (stall_count/flush_count) under HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 1,
  parameter int unsigned CNT_W             = 4
) (
  input  logic             clk,
  input  logic             btnc_i,
  input  logic [31:0]      instruction,
  input  logic             ID_EX_MemRead_r,
  input  logic [REG_W-1:0] ID_EX_write_register_r,
  input  logic             branch_taken_i,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic [1:0]       hazard_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      stall_count,
  output logic [31:0]      flush_count
`endif
);

  localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam hazard_state_e    STALL_NEXT   = (LOAD_STALL_CYCLES > 1) ? StStall : StRun;
  localparam hazard_state_e    FLUSH_NEXT   = (FLUSH_CYCLES > 1) ? StFlush : StRun;

  hazard_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;

  load_use_detect u_load_use_detect (
    .instruction    (instruction),
    .mem_read       (ID_EX_MemRead_r),
    .write_register (ID_EX_write_register_r),
    .load_use       (load_use)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;

    if (branch_taken_i) begin
      // A taken branch wins in every state: squash the wrong path and restart the flush window.
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
      cnt_d        = FLUSH_RELOAD;
      state_d      = FLUSH_NEXT;
    end else begin
      case (state_q)
        StStall: begin
          PC_write     = 1'b0;
          IF_ID_write  = 1'b0;
          ID_EX_bubble = 1'b1;
          if (cnt_q > CNT_ONE) cnt_d = cnt_q - CNT_ONE;
          else                 state_d = StRun;
        end
        StFlush: begin
          IF_ID_flush  = 1'b1;
          ID_EX_bubble = 1'b1;
          if (cnt_q > CNT_ONE) cnt_d = cnt_q - CNT_ONE;
          else                 state_d = StRun;
        end
        default: begin
          state_d = StRun;
          if (load_use) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
            cnt_d        = STALL_RELOAD;
            state_d      = STALL_NEXT;
          end
        end
      endcase
    end

    if (btnc_i) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge btnc_i) begin
    if (btnc_i) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hazard_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge btnc_i) begin
    if (btnc_i) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (ID_EX_bubble && !IF_ID_flush && (stall_count != '1)) stall_count <= stall_count + 32'd1;
      if (IF_ID_flush && (flush_count != '1))                  flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: default instance (1/1) and a 3-stall/2-flush instance.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        btnc_i;
  logic [31:0] instruction;
  logic        mem_read;
  logic [4:0]  wreg;
  logic        br;

  logic       a_pc, a_ifw, a_fl, a_bub;
  logic [1:0] a_st;
  logic       b_pc, b_ifw, b_fl, b_bub;
  logic [1:0] b_st;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] a_sc, a_fc, b_sc, b_fc;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int sl_a = 0, fl_a = 0, sl_b = 0, fl_b = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl u_a (
    .clk                    (clk),
    .btnc_i                 (btnc_i),
    .instruction            (instruction),
    .ID_EX_MemRead_r        (mem_read),
    .ID_EX_write_register_r (wreg),
    .branch_taken_i         (br),
    .PC_write               (a_pc),
    .IF_ID_write            (a_ifw),
    .IF_ID_flush            (a_fl),
    .ID_EX_bubble           (a_bub),
    .hazard_state           (a_st)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_count            (a_sc),
    .flush_count            (a_fc)
`endif
  );

  hazard_stall_ctrl #(
    .LOAD_STALL_CYCLES (3),
    .FLUSH_CYCLES      (2),
    .CNT_W             (4)
  ) u_b (
    .clk                    (clk),
    .btnc_i                 (btnc_i),
    .instruction            (instruction),
    .ID_EX_MemRead_r        (mem_read),
    .ID_EX_write_register_r (wreg),
    .branch_taken_i         (br),
    .PC_write               (b_pc),
    .IF_ID_write            (b_ifw),
    .IF_ID_flush            (b_fl),
    .ID_EX_bubble           (b_bub),
    .hazard_state           (b_st)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_count            (b_sc),
    .flush_count            (b_fc)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt);
    return {op, rs, rt, 16'h1234};
  endfunction

  function automatic bit ref_lu(input logic [31:0] ins, input logic mr, input logic [4:0] wr);
    bit rt_src;
    rt_src = ins[31:26] inside {6'h00, 6'h04, 6'h05, 6'h2b};
    return mr && (wr != 5'd0) && ((wr == ins[25:21]) || (rt_src && (wr == ins[20:16])));
  endfunction

  // Reference: sl/fl = further stall/flush cycles still owed after the current one.
  // Result packs {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, hazard_state}.
  task automatic model(input int lsc, input int fc, input bit rst, input bit lu, input bit b,
                       inout int sl, inout int fl, output logic [5:0] e);
    logic [1:0] st;
    if (rst) begin
      e  = 6'b0011_00;
      sl = 0;
      fl = 0;
    end else begin
      st = (fl > 0) ? 2'd2 : ((sl > 0) ? 2'd1 : 2'd0);
      if (b) begin
        e  = {4'b1111, st};
        fl = fc - 1;
        sl = 0;
      end else if (fl > 0) begin
        e = {4'b1111, st};
        fl--;
      end else if (sl > 0) begin
        e = {4'b0001, st};
        sl--;
      end else if (lu) begin
        e  = {4'b0001, st};
        sl = lsc - 1;
      end else begin
        e = {4'b1100, st};
      end
    end
  endtask

  // Drives one cycle's inputs and checks both instances at the following negedge.
  task automatic run_cycle(input logic [31:0] ins, input logic mr, input logic [4:0] wr,
                           input logic b, input logic rst);
    logic [5:0] ea, eb;
    bit lu;
    instruction = ins;
    mem_read    = mr;
    wreg        = wr;
    br          = b;
    btnc_i      = rst;
    lu = ref_lu(ins, mr, wr);
    model(1, 1, rst, lu, b, sl_a, fl_a, ea);
    model(3, 2, rst, lu, b, sl_b, fl_b, eb);
    @(negedge clk);
    chk("model_a", {26'd0, a_pc, a_ifw, a_fl, a_bub, a_st}, {26'd0, ea});
    chk("model_b", {26'd0, b_pc, b_ifw, b_fl, b_bub, b_st}, {26'd0, eb});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic        mr;
    logic [4:0]  wr;
    logic        b;
    logic [3:0]  exp;
  } vec_t;

  vec_t tbl[9];
  logic [31:0] nop_ins;
  logic [31:0] hz_ins;
  logic [5:0]  rnd_op[6];

  initial begin
    nop_ins = mk(6'h00, 5'd1, 5'd2);
    hz_ins  = mk(6'h00, 5'd8, 5'd10);
    rnd_op  = '{6'h00, 6'h04, 6'h05, 6'h23, 6'h2b, 6'h08};

    tbl[0] = '{"rs_hazard",  hz_ins,                    1'b1, 5'd8, 1'b0, 4'b0001};
    tbl[1] = '{"no_load",    hz_ins,                    1'b0, 5'd8, 1'b0, 4'b1100};
    tbl[2] = '{"reg0",       mk(6'h00, 5'd0, 5'd0),     1'b1, 5'd0, 1'b0, 4'b1100};
    tbl[3] = '{"sw_rt",      mk(6'h2b, 5'd3, 5'd8),     1'b1, 5'd8, 1'b0, 4'b0001};
    tbl[4] = '{"addi_rt",    mk(6'h08, 5'd3, 5'd8),     1'b1, 5'd8, 1'b0, 4'b1100};
    tbl[5] = '{"beq_rt",     mk(6'h04, 5'd3, 5'd8),     1'b1, 5'd8, 1'b0, 4'b0001};
    tbl[6] = '{"br_over_lu", hz_ins,                    1'b1, 5'd8, 1'b1, 4'b1111};
    tbl[7] = '{"lw_rt_dest", mk(6'h23, 5'd3, 5'd8),     1'b1, 5'd8, 1'b0, 4'b1100};
    tbl[8] = '{"br_only",    nop_ins,                   1'b0, 5'd0, 1'b1, 4'b1111};

    // Reset state
    run_cycle(nop_ins, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("rst_a_outs", {a_pc, a_ifw, a_fl, a_bub}, 4'b0011);
    chk("rst_b_state", b_st, 2'b00);
    tick();
    run_cycle(nop_ins, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("post_rst_run", {b_pc, b_ifw, b_st}, 4'b1100);
    tick();

    for (int i = 0; i < 9; i++) begin
      run_cycle(tbl[i].ins, tbl[i].mr, tbl[i].wr, tbl[i].b, 1'b0);
      chk(tbl[i].name, {a_pc, a_ifw, a_fl, a_bub}, tbl[i].exp);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      run_cycle(nop_ins, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
    end

    // Three-cycle stall on u_b
    run_cycle(hz_ins, 1'b1, 5'd8, 1'b0, 1'b0);
    chk("stall_c1", {b_pc, b_ifw, b_fl, b_bub, b_st}, 6'b0001_00);
    tick();
    run_cycle(nop_ins, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("stall_c2", {b_pc, b_ifw, b_fl, b_bub, b_st}, 6'b0001_01);
    tick();
    run_cycle(nop_ins, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("stall_c3", {b_pc, b_ifw, b_fl, b_bub, b_st}, 6'b0001_01);
    tick();
    run_cycle(nop_ins, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("stall_done", {b_pc, b_ifw, b_fl, b_bub, b_st}, 6'b1100_00);
    tick();

    // Branch together with a load-use hazard, two-cycle flush
    run_cycle(hz_ins, 1'b1, 5'd8, 1'b1, 1'b0);
    chk("brlu_c1", {b_pc, b_ifw, b_fl, b_bub, b_st}, 6'b1111_00);
    tick();
    run_cycle(hz_ins, 1'b1, 5'd8, 1'b0, 1'b0);
    chk("brlu_c2", {b_pc, b_ifw, b_fl, b_bub, b_st}, 6'b1111_10);
    tick();
    run_cycle(nop_ins, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("brlu_done", {b_pc, b_ifw, b_fl, b_bub, b_st}, 6'b1100_00);
    tick();

    // Reset pulse while stalled with cnt=2
    run_cycle(hz_ins, 1'b1, 5'd8, 1'b0, 1'b0);
    tick();
    run_cycle(nop_ins, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("mid_rst", {b_pc, b_ifw, b_fl, b_bub, b_st}, 6'b0011_00);
    tick();
    run_cycle(nop_ins, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("after_rst", {b_pc, b_ifw, b_fl, b_bub, b_st}, 6'b1100_00);
    tick();

`ifdef HAZARD_PERF_CNT_EN
    run_cycle(nop_ins, 1'b0, 5'd0, 1'b0, 1'b1);
    tick();
    run_cycle(hz_ins, 1'b1, 5'd8, 1'b0, 1'b0);
    tick();
    run_cycle(nop_ins, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    run_cycle(nop_ins, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    run_cycle(nop_ins, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    run_cycle(nop_ins, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    run_cycle(nop_ins, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("perf_b_stall", b_sc, 32'd3);
    chk("perf_b_flush", b_fc, 32'd2);
    chk("perf_a_stall", a_sc, 32'd1);
    chk("perf_a_flush", a_fc, 32'd1);
    tick();
    run_cycle(nop_ins, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("perf_rst_stall", b_sc, 32'd0);
    chk("perf_rst_flush", b_fc, 32'd0);
    tick();
`endif

    // Random traffic against the reference model
    for (int i = 0; i < 500; i++) begin
      run_cycle(mk(rnd_op[$urandom_range(0, 5)], 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3))),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
